// File: rtl/rd_req_arbiter.sv
// Round-robin arbiter that shares one AXI AR channel among four read managers.
// One grant at a time; the grant is released after the handshake, a withdrawal or a timeout.
module rd_req_arbiter #(
    parameter logic [7:0]  GNT_TIMEOUT = 8'd64,
    parameter int unsigned NUM_M       = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_rq,
    output logic [3:0]   gnt_rq,
    input  logic [3:0]   m_arvalid,
    output logic [3:0]   m_arready,
    input  logic [15:0]  m_arid,
    input  logic [127:0] m_araddr,
    output logic         s_arvalid,
    input  logic         s_arready,
    output logic [3:0]   s_arid,
    output logic [31:0]  s_araddr,
    output logic [1:0]   owner,
    output logic         busy,
    output logic         id_err
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  owner_q, owner_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        seen_q, seen_d;
    logic        id_err_q, id_err_d;

    logic        granted;
    logic        own_valid;
    logic [3:0]  own_id;
    logic [31:0] own_addr;
    logic        hs;
    logic        withdraw;
    logic        timeout_hit;
    logic        sel_found;
    logic [1:0]  sel_idx;
    logic [1:0]  cand;

    assign granted   = (state_q == StGrant);
    assign own_valid = m_arvalid[owner_q];
    assign own_id    = m_arid[{owner_q, 2'b00} +: 4];
    assign own_addr  = m_araddr[{owner_q, 5'b00000} +: 32];

    always_comb begin
        s_arvalid = 1'b0;
        s_arid    = '0;
        s_araddr  = '0;
        m_arready = '0;
        if (granted) begin
            s_arvalid          = own_valid;
            s_arid             = own_id;
            s_araddr           = own_addr;
            m_arready[owner_q] = s_arready;
        end
    end

    assign hs       = s_arvalid & s_arready;
    assign withdraw = ~req_rq[owner_q] & ~own_valid;
    // Once the owner has shown arvalid the timeout is frozen so a valid AR is never dropped.
    assign timeout_hit = (GNT_TIMEOUT != 8'd0) && !seen_q && !own_valid &&
                         (cnt_q == GNT_TIMEOUT - 8'd1);

    // Scan owner+1, owner+2, ... so the last owner ends up with lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = owner_q;
        cand      = owner_q;
        for (int unsigned k = 1; k <= NUM_M; k++) begin
            cand = owner_q + 2'(k);
            if (!sel_found && req_rq[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        id_err_d = id_err_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d = StGrant;
                    gnt_d   = 4'b0001 << sel_idx;
                    owner_d = sel_idx;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            StGrant: begin
                if (hs) begin
                    if (s_arid[3:2] != owner_q) id_err_d = 1'b1;
                    state_d = StIdle;
                    gnt_d   = '0;
                end else if (withdraw || timeout_hit) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end else begin
                    seen_d = seen_q | own_valid;
                    if (!own_valid && !seen_q) cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            owner_q  <= 2'd3;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            id_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            id_err_q <= id_err_d;
        end
    end

    assign gnt_rq = gnt_q;
    assign owner  = owner_q;
    assign busy   = granted;
    assign id_err = id_err_q;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Directed bench for rd_req_arbiter; AR beats are scoreboarded at drive time and
// checked when the shared-channel handshake occurs.
module tb_rd_req_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_rq;
    logic [3:0]   gnt_rq;
    logic [3:0]   m_arvalid;
    logic [3:0]   m_arready;
    logic [15:0]  m_arid;
    logic [127:0] m_araddr;
    logic         s_arvalid;
    logic         s_arready;
    logic [3:0]   s_arid;
    logic [31:0]  s_araddr;
    logic [1:0]   owner;
    logic         busy;
    logic         id_err;

    int total = 0;
    int bad   = 0;
    logic [37:0] sb[$];
    logic [3:0]  exp_order[5];

    rd_req_arbiter #(
        .GNT_TIMEOUT(8'd4),
        .NUM_M      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_rq   (req_rq),
        .gnt_rq   (gnt_rq),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_arid   (m_arid),
        .m_araddr (m_araddr),
        .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_arid   (s_arid),
        .s_araddr (s_araddr),
        .owner    (owner),
        .busy     (busy),
        .id_err   (id_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic v, input logic [3:0] id,
                         input logic [31:0] addr);
        m_arvalid[i]         = v;
        m_arid[4*i +: 4]     = id;
        m_araddr[32*i +: 32] = addr;
    endtask

    // Wait (bounded) for the handshake, compare the beat with the scoreboard, take the edge.
    task automatic handshake(input string tag);
        int n;
        logic [37:0] e;
        n = 0;
        #1;
        while (!(s_arvalid && s_arready) && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_hs_wait"}, 64'(n < 20), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_beat"}, {26'd0, owner, s_arid, s_araddr}, {26'd0, e});
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_rq    = '0;
        m_arvalid = '0;
        m_arid    = '0;
        m_araddr  = '0;
        s_arready = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 64'(gnt_rq), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_owner", 64'(owner), 64'h3);
        chk("rst_iderr", 64'(id_err), 64'h0);
        chk("rst_svalid", 64'(s_arvalid), 64'h0);
        rst_n = 1'b1;

        // Single request from master 2.
        req_rq = 4'b0100;
        tick();
        chk("single_gnt", 64'(gnt_rq), 64'h4);
        chk("single_owner", 64'(owner), 64'h2);
        chk("single_busy", 64'(busy), 64'h1);
        set_m(2, 1'b1, 4'b1000, 32'h0000_1000);
        sb.push_back({2'd2, 4'b1000, 32'h0000_1000});
        #1;
        chk("single_svalid", 64'(s_arvalid), 64'h1);
        chk("single_ready_lo", 64'(m_arready), 64'h0);
        s_arready = 1'b1;
        #1;
        chk("single_ready", 64'(m_arready), 64'h4);
        handshake("single");
        chk("single_rel_gnt", 64'(gnt_rq), 64'h0);
        chk("single_rel_owner", 64'(owner), 64'h2);
        chk("single_iderr", 64'(id_err), 64'h0);
        req_rq    = '0;
        m_arvalid = '0;
        s_arready = 1'b0;
        tick();

        // Round robin from a fresh reset with everyone requesting.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            m_arid[4*i +: 4]     = {2'(i), 2'b01};
            m_araddr[32*i +: 32] = 32'hA000_0000 + 32'(i * 16);
        end
        req_rq    = 4'b1111;
        s_arready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gnt", 64'(gnt_rq), 64'(exp_order[k]));
            m_arvalid = gnt_rq;
            for (int i = 0; i < 4; i++) begin
                if (exp_order[k][i]) sb.push_back({2'(i), 2'(i), 2'b01, 32'hA000_0000 + 32'(i * 16)});
            end
            handshake("rr");
            chk("rr_bubble", 64'({busy, gnt_rq}), 64'h0);
            m_arvalid = '0;
        end
        req_rq    = '0;
        s_arready = 1'b0;
        tick();

        // Backpressure on master 1: no timeout while arvalid is held.
        req_rq = 4'b0010;
        tick();
        chk("bp_gnt", 64'(gnt_rq), 64'h2);
        set_m(1, 1'b1, 4'b0111, 32'h0000_2000);
        sb.push_back({2'd1, 4'b0111, 32'h0000_2000});
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_hold", 64'({gnt_rq, s_arvalid, m_arready}), 64'({4'b0010, 1'b1, 4'b0000}));
        end
        s_arready = 1'b1;
        handshake("bp");
        chk("bp_rel", 64'(gnt_rq), 64'h0);
        req_rq    = '0;
        m_arvalid = '0;
        s_arready = 1'b0;

        // Timeout on master 3 with master 0 pending, then master 0 withdraws.
        req_rq = 4'b1001;
        tick();
        chk("to_gnt", 64'(gnt_rq), 64'h8);
        tick();
        chk("to_c2", 64'(gnt_rq), 64'h8);
        tick();
        tick();
        chk("to_c4", 64'(gnt_rq), 64'h8);
        tick();
        chk("to_rel", 64'({busy, gnt_rq}), 64'h0);
        tick();
        chk("to_next", 64'(gnt_rq), 64'h1);
        req_rq = '0;
        tick();
        chk("wd_rel", 64'({busy, gnt_rq}), 64'h0);
        chk("wd_owner", 64'(owner), 64'h0);

        // Handshake with a mismatched id sets the sticky error flag.
        req_rq = 4'b0100;
        tick();
        chk("id_gnt", 64'(gnt_rq), 64'h4);
        set_m(2, 1'b1, 4'b0100, 32'h0000_3000);
        sb.push_back({2'd2, 4'b0100, 32'h0000_3000});
        s_arready = 1'b1;
        handshake("id");
        chk("id_err_set", 64'(id_err), 64'h1);
        req_rq    = '0;
        m_arvalid = '0;
        s_arready = 1'b0;
        tick();
        tick();
        chk("id_err_sticky", 64'(id_err), 64'h1);

        // Reset while master 1 holds a valid AR.
        req_rq = 4'b0010;
        tick();
        chk("mr_gnt", 64'(gnt_rq), 64'h2);
        m_arvalid[1] = 1'b1;
        #1;
        chk("mr_svalid", 64'(s_arvalid), 64'h1);
        rst_n = 1'b0;
        tick();
        chk("mr_gnt0", 64'(gnt_rq), 64'h0);
        chk("mr_svalid0", 64'(s_arvalid), 64'h0);
        chk("mr_owner", 64'(owner), 64'h3);
        chk("mr_busy", 64'(busy), 64'h0);
        chk("mr_iderr", 64'(id_err), 64'h0);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
